// File: rtl/pixel_pkg.sv
// Shared colour constants, default widths and layer identifiers for the pixel
// compositor pipeline.
package pixel_pkg;

    localparam int SCREEN_WIDTH_DEF = 10;
    localparam int PHY_WIDTH_DEF    = 14;
    localparam int PIXEL_WIDTH_DEF  = 12;

    localparam logic [11:0] BLACK       = 12'h000;
    localparam logic [11:0] TRANSPARENT = 12'hF0F;

    typedef enum logic [1:0] {
        LAYER_BG   = 2'd0,
        LAYER_MAP  = 2'd1,
        LAYER_OBS  = 2'd2,
        LAYER_CHAR = 2'd3
    } layer_e;

endpackage

// File: rtl/obstacle_hit_encoder.sv
// Per-channel obstacle rectangle test followed by a lowest-index priority
// encoder that picks the single obstacle fetched for the current pixel.
module obstacle_hit_encoder #(
    parameter int PHY_WIDTH       = 14,
    parameter int OBSTACLE_NUM    = 7,
    parameter int OBSTACLE_WIDTH  = 10,
    parameter int OBSTACLE_HEIGHT = 20,
    parameter int BLOCK_LEN_WIDTH = 4,
    parameter int OB_ID_W         = 3
) (
    input  logic [PHY_WIDTH-1:0]                    px,
    input  logic [PHY_WIDTH-1:0]                    py,
    input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       obs_x,
    input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       obs_y,
    input  logic [OBSTACLE_NUM*BLOCK_LEN_WIDTH-1:0] obs_len,
    output logic [OBSTACLE_NUM-1:0]                 hit,
    output logic                                    hit_valid,
    output logic [OB_ID_W-1:0]                      hit_id
);

    genvar gi;
    generate
        for (gi = 0; gi < OBSTACLE_NUM; gi++) begin : g_obs
            logic [PHY_WIDTH-1:0]       ox;
            logic [PHY_WIDTH-1:0]       oy;
            logic [BLOCK_LEN_WIDTH-1:0] len;
            logic [PHY_WIDTH:0]         x_hi;
            logic [PHY_WIDTH:0]         y_hi;

            assign ox  = obs_x[gi*PHY_WIDTH +: PHY_WIDTH];
            assign oy  = obs_y[gi*PHY_WIDTH +: PHY_WIDTH];
            assign len = obs_len[gi*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
            // One extra bit keeps the upper bounds from wrapping near the top of the space.
            assign x_hi = {1'b0, ox} + (PHY_WIDTH+1)'(32'(len) * 32'(OBSTACLE_WIDTH));
            assign y_hi = {1'b0, oy} + (PHY_WIDTH+1)'(OBSTACLE_HEIGHT);

            assign hit[gi] = (len != '0) && (px >= ox) && ({1'b0, px} < x_hi)
                             && (py >= oy) && ({1'b0, py} < y_hi);
        end
    endgenerate

    always_comb begin
        hit_valid = 1'b0;
        hit_id    = '0;
        for (int i = OBSTACLE_NUM - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_valid = 1'b1;
                hit_id    = OB_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/pixel_compositor_pipe.sv
// Three-stage pixel compositor: hit test, ROM address issue, layer resolve,
// registered RGB out, with per-frame position shadows and collision flags.
module pixel_compositor_pipe #(
    parameter int              SCREEN_WIDTH    = 10,
    parameter int              PHY_WIDTH       = 14,
    parameter int              PIXEL_WIDTH     = 12,
    parameter int              CAMERA_WIDTH    = 5,
    parameter int              BLOCK_WIDTH     = 480,
    parameter int              OBSTACLE_NUM    = 7,
    parameter int              OBSTACLE_WIDTH  = 10,
    parameter int              OBSTACLE_HEIGHT = 20,
    parameter int              BLOCK_LEN_WIDTH = 4,
    parameter int              CHAR_WIDTH_X    = 42,
    parameter int              CHAR_WIDTH_Y    = 52,
    parameter int              MAP_X_OFFSET    = 120,
    parameter int              MAP_WIDTH_X     = 480,
    parameter int              WALL_WIDTH      = 10,
    parameter logic [11:0]     TRANSPARENT     = 12'hF0F,
    parameter int              OB_ID_W         = (OBSTACLE_NUM > 1) ? $clog2(OBSTACLE_NUM) : 1
) (
    input  logic                                    sys_clk,
    input  logic                                    sys_rst,
    input  logic                                    frame_start,
    input  logic                                    pix_valid,
    input  logic                                    video_on,
    input  logic [SCREEN_WIDTH-1:0]                 x,
    input  logic [SCREEN_WIDTH-1:0]                 y,
    input  logic [CAMERA_WIDTH-1:0]                 camera_y,
    input  logic [PHY_WIDTH-1:0]                    char_abs_x,
    input  logic [PHY_WIDTH-1:0]                    char_abs_y,
    input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       obstacle_abs_pos_x,
    input  logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       obstacle_abs_pos_y,
    input  logic [OBSTACLE_NUM*BLOCK_LEN_WIDTH-1:0] obstacle_block_width,
    output logic [SCREEN_WIDTH-1:0]                 char_x_rom,
    output logic [SCREEN_WIDTH-1:0]                 char_y_rom,
    output logic [SCREEN_WIDTH-1:0]                 obs_x_rom,
    output logic [SCREEN_WIDTH-1:0]                 obs_y_rom,
    output logic [OB_ID_W-1:0]                      obs_id,
    output logic [PHY_WIDTH-1:0]                    map_x,
    output logic [PHY_WIDTH-1:0]                    map_y,
    input  logic [PIXEL_WIDTH-1:0]                  char_rgb,
    input  logic [PIXEL_WIDTH-1:0]                  obs_rgb,
    input  logic [PIXEL_WIDTH-1:0]                  map_rgb,
    input  logic [PIXEL_WIDTH-1:0]                  bg_rgb,
    output logic [PIXEL_WIDTH-1:0]                  rgb,
    output logic                                    rgb_valid,
    output logic [OBSTACLE_NUM-1:0]                 collision_flags,
    output logic                                    collision_any
);
    import pixel_pkg::*;

    localparam logic [PHY_WIDTH:0]   MAP_LO = (PHY_WIDTH+1)'(MAP_X_OFFSET + WALL_WIDTH);
    localparam logic [PHY_WIDTH:0]   MAP_HI = (PHY_WIDTH+1)'(MAP_X_OFFSET + MAP_WIDTH_X - WALL_WIDTH);
    localparam logic [PHY_WIDTH-1:0] MAP_X0 = PHY_WIDTH'(MAP_X_OFFSET + WALL_WIDTH);
    localparam logic [PHY_WIDTH-1:0] WALL_Y = PHY_WIDTH'(WALL_WIDTH);

    logic [PHY_WIDTH-1:0]                    char_x_sh, char_y_sh, cam_off_sh;
    logic [OBSTACLE_NUM*PHY_WIDTH-1:0]       obs_x_sh, obs_y_sh;
    logic [OBSTACLE_NUM*BLOCK_LEN_WIDTH-1:0] obs_len_sh;
    logic [OBSTACLE_NUM-1:0]                 acc_reg, hit_now;

    logic [PHY_WIDTH-1:0] px, py, ay, win_ox, win_oy;
    logic [PHY_WIDTH-1:0] sh_ox [OBSTACLE_NUM];
    logic [PHY_WIDTH-1:0] sh_oy [OBSTACLE_NUM];
    logic [OBSTACLE_NUM-1:0] obs_hit;
    logic                    hit_valid, char_on0, map_on0, obs_on0;
    logic [OB_ID_W-1:0]      hit_id;

    logic s1_valid, s1_video, s1_char_on, s1_obs_on, s1_map_on;
    logic s2_valid, s2_video, s2_char_on, s2_obs_on, s2_map_on;
    logic [OB_ID_W-1:0]     s2_obs_id;
    logic                   char_opaque, obs_opaque;
    layer_e                 layer;
    logic [PIXEL_WIDTH-1:0] pix_out;

    genvar gi;
    generate
        for (gi = 0; gi < OBSTACLE_NUM; gi++) begin : g_unpack
            assign sh_ox[gi] = obs_x_sh[gi*PHY_WIDTH +: PHY_WIDTH];
            assign sh_oy[gi] = obs_y_sh[gi*PHY_WIDTH +: PHY_WIDTH];
        end
    endgenerate

    // Stage 0: absolute-coordinate layer tests against the frame shadows.
    assign px = PHY_WIDTH'(x);
    assign py = PHY_WIDTH'(y);
    assign ay = py + cam_off_sh;

    assign char_on0 = (px >= char_x_sh) && ({1'b0, px} < {1'b0, char_x_sh} + (PHY_WIDTH+1)'(CHAR_WIDTH_X))
                      && (ay >= char_y_sh) && ({1'b0, ay} < {1'b0, char_y_sh} + (PHY_WIDTH+1)'(CHAR_WIDTH_Y));
    assign map_on0  = ({1'b0, px} >= MAP_LO) && ({1'b0, px} < MAP_HI) && (py >= WALL_Y);

    obstacle_hit_encoder #(
        .PHY_WIDTH      (PHY_WIDTH),
        .OBSTACLE_NUM   (OBSTACLE_NUM),
        .OBSTACLE_WIDTH (OBSTACLE_WIDTH),
        .OBSTACLE_HEIGHT(OBSTACLE_HEIGHT),
        .BLOCK_LEN_WIDTH(BLOCK_LEN_WIDTH),
        .OB_ID_W        (OB_ID_W)
    ) u_hit (
        .px       (px),
        .py       (ay),
        .obs_x    (obs_x_sh),
        .obs_y    (obs_y_sh),
        .obs_len  (obs_len_sh),
        .hit      (obs_hit),
        .hit_valid(hit_valid),
        .hit_id   (hit_id)
    );

    assign obs_on0 = hit_valid & obs_hit[hit_id];
    assign win_ox  = sh_ox[hit_id];
    assign win_oy  = sh_oy[hit_id];

    // Stage 2: ROM data is valid now; resolve which layer is visible.
    assign char_opaque = s2_char_on && (char_rgb != PIXEL_WIDTH'(TRANSPARENT));
    assign obs_opaque  = s2_obs_on && (obs_rgb != PIXEL_WIDTH'(TRANSPARENT));

    always_comb begin
        layer = LAYER_BG;
        if (char_opaque)     layer = LAYER_CHAR;
        else if (obs_opaque) layer = LAYER_OBS;
        else if (s2_map_on)  layer = LAYER_MAP;
        case (layer)
            LAYER_CHAR: pix_out = char_rgb;
            LAYER_OBS:  pix_out = obs_rgb;
            LAYER_MAP:  pix_out = map_rgb;
            default:    pix_out = bg_rgb;
        endcase
        if (!s2_video) pix_out = PIXEL_WIDTH'(BLACK);
    end

    assign hit_now = (s2_valid && s2_video && char_opaque && obs_opaque)
                     ? (OBSTACLE_NUM'(1) << s2_obs_id) : '0;
    assign collision_any = |collision_flags;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            char_x_sh       <= '0;
            char_y_sh       <= '0;
            cam_off_sh      <= '0;
            obs_x_sh        <= '0;
            obs_y_sh        <= '0;
            obs_len_sh      <= '0;
            acc_reg         <= '0;
            collision_flags <= '0;
        end else if (frame_start) begin
            char_x_sh       <= char_abs_x;
            char_y_sh       <= char_abs_y;
            cam_off_sh      <= PHY_WIDTH'(32'(camera_y) * 32'(BLOCK_WIDTH));
            obs_x_sh        <= obstacle_abs_pos_x;
            obs_y_sh        <= obstacle_abs_pos_y;
            obs_len_sh      <= obstacle_block_width;
            collision_flags <= acc_reg | hit_now;
            acc_reg         <= '0;
        end else begin
            acc_reg         <= acc_reg | hit_now;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            char_x_rom <= '0;  char_y_rom <= '0;
            obs_x_rom  <= '0;  obs_y_rom  <= '0;
            obs_id     <= '0;
            map_x      <= '0;  map_y      <= '0;
            s1_valid   <= 1'b0; s1_video  <= 1'b0;
            s1_char_on <= 1'b0; s1_obs_on <= 1'b0; s1_map_on <= 1'b0;
            s2_valid   <= 1'b0; s2_video  <= 1'b0;
            s2_char_on <= 1'b0; s2_obs_on <= 1'b0; s2_map_on <= 1'b0;
            s2_obs_id  <= '0;
            rgb        <= '0;
            rgb_valid  <= 1'b0;
        end else begin
            char_x_rom <= SCREEN_WIDTH'(px - char_x_sh);
            char_y_rom <= SCREEN_WIDTH'(ay - char_y_sh);
            obs_x_rom  <= SCREEN_WIDTH'((px - win_ox) % PHY_WIDTH'(OBSTACLE_WIDTH));
            obs_y_rom  <= SCREEN_WIDTH'(ay - win_oy);
            obs_id     <= hit_id;
            map_x      <= px - MAP_X0;
            map_y      <= ay - WALL_Y;
            s1_valid   <= pix_valid;
            s1_video   <= video_on;
            s1_char_on <= char_on0;
            s1_obs_on  <= obs_on0;
            s1_map_on  <= map_on0;

            s2_valid   <= s1_valid;
            s2_video   <= s1_video;
            s2_char_on <= s1_char_on;
            s2_obs_on  <= s1_obs_on;
            s2_map_on  <= s1_map_on;
            s2_obs_id  <= obs_id;

            rgb_valid  <= s2_valid;
            if (s2_valid) rgb <= pix_out;
        end
    end

endmodule

// File: tb/tb_pixel_compositor_pipe.sv
// Directed bench for pixel_compositor_pipe: latency, shadows, priority,
// obstacle width, collision flags and asynchronous reset.
module tb_pixel_compositor_pipe;

    localparam int N   = 7;
    localparam int PW  = 14;
    localparam int SW  = 10;
    localparam int PXW = 12;
    localparam int BLW = 4;

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic            frame_start = 1'b0;
    logic            pix_valid = 1'b0;
    logic            video_on = 1'b0;
    logic [SW-1:0]   x = '0, y = '0;
    logic [4:0]      camera_y = '0;
    logic [PW-1:0]   char_abs_x = '0, char_abs_y = '0;
    logic [N*PW-1:0] obstacle_abs_pos_x = '0, obstacle_abs_pos_y = '0;
    logic [N*BLW-1:0] obstacle_block_width = '0;
    logic [PXW-1:0]  char_rgb = 12'hABC, obs_rgb = 12'h456, map_rgb = 12'h0F0, bg_rgb = 12'h123;

    logic [SW-1:0]   char_x_rom, char_y_rom, obs_x_rom, obs_y_rom;
    logic [2:0]      obs_id;
    logic [PW-1:0]   map_x, map_y;
    logic [PXW-1:0]  rgb;
    logic            rgb_valid;
    logic [N-1:0]    collision_flags;
    logic            collision_any;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    pixel_compositor_pipe dut (
        .sys_clk             (sys_clk),
        .sys_rst             (sys_rst),
        .frame_start         (frame_start),
        .pix_valid           (pix_valid),
        .video_on            (video_on),
        .x                   (x),
        .y                   (y),
        .camera_y            (camera_y),
        .char_abs_x          (char_abs_x),
        .char_abs_y          (char_abs_y),
        .obstacle_abs_pos_x  (obstacle_abs_pos_x),
        .obstacle_abs_pos_y  (obstacle_abs_pos_y),
        .obstacle_block_width(obstacle_block_width),
        .char_x_rom          (char_x_rom),
        .char_y_rom          (char_y_rom),
        .obs_x_rom           (obs_x_rom),
        .obs_y_rom           (obs_y_rom),
        .obs_id              (obs_id),
        .map_x               (map_x),
        .map_y               (map_y),
        .char_rgb            (char_rgb),
        .obs_rgb             (obs_rgb),
        .map_rgb             (map_rgb),
        .bg_rgb              (bg_rgb),
        .rgb                 (rgb),
        .rgb_valid           (rgb_valid),
        .collision_flags     (collision_flags),
        .collision_any       (collision_any)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One-cycle pixel; on return the stage-1 ROM addresses are visible.
    task automatic send(input logic [SW-1:0] px, input logic [SW-1:0] py);
        x = px;
        y = py;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic set_obs(input int i, input int ox, input int oy, input int len);
        obstacle_abs_pos_x[i*PW +: PW]     = PW'(ox);
        obstacle_abs_pos_y[i*PW +: PW]     = PW'(oy);
        obstacle_block_width[i*BLW +: BLW] = BLW'(len);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("reset_rgb", rgb, 12'h000);
        chk("reset_rgb_valid", rgb_valid, 1'b0);
        chk("reset_flags", collision_flags, 7'h00);
        chk("reset_any", collision_any, 1'b0);
        chk("reset_obs_id", obs_id, 3'd0);
        sys_rst = 1'b0;
        tick();

        // Bubbles 1,0,1 with video off.
        x = 10'd600; y = 10'd300; video_on = 1'b0;
        pix_valid = 1'b1; tick();
        pix_valid = 1'b0; tick();
        chk("lat_not_yet", rgb_valid, 1'b0);
        pix_valid = 1'b1; tick();
        chk("bubble_v0", rgb_valid, 1'b1);
        chk("bubble_rgb0", rgb, 12'h000);
        pix_valid = 1'b0; tick();
        chk("bubble_v1", rgb_valid, 1'b0);
        tick();
        chk("bubble_v2", rgb_valid, 1'b1);
        chk("bubble_rgb2", rgb, 12'h000);
        tick();

        // Frame F1 shadows; the pixel in the frame_start cycle sees the old ones.
        camera_y = 5'd1; char_abs_x = 14'd300; char_abs_y = 14'd500;
        set_obs(0, 200, 600, 0);
        set_obs(2, 200, 600, 3);
        set_obs(5, 210, 605, 2);
        set_obs(4, 400, 700, 1);
        video_on = 1'b1;
        x = 10'd300; y = 10'd20; pix_valid = 1'b1; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; pix_valid = 1'b0;
        chk("old_shadow_cx", char_x_rom, 10'd300);
        chk("old_shadow_cy", char_y_rom, 10'd20);
        tick(); tick();
        chk("old_shadow_valid", rgb_valid, 1'b1);
        chk("old_shadow_rgb", rgb, 12'h0F0);

        send(10'd300, 10'd20);
        chk("cam_char_x", char_x_rom, 10'd0);
        chk("cam_char_y", char_y_rom, 10'd0);
        chk("cam_map_x", map_x, 14'd170);
        chk("cam_map_y", map_y, 14'd490);
        chk("cam_obs_none", obs_id, 3'd0);
        tick(); tick();
        chk("char_rgb", rgb, 12'hABC);

        obs_rgb = 12'hF0F;
        send(10'd215, 10'd126);
        chk("overlap_id", obs_id, 3'd2);
        chk("overlap_ox", obs_x_rom, 10'd5);
        chk("overlap_oy", obs_y_rom, 10'd6);
        tick(); tick();
        chk("obs_transp_map", rgb, 12'h0F0);

        obs_rgb = 12'h456;
        send(10'd215, 10'd126);
        tick(); tick();
        chk("obs_opaque", rgb, 12'h456);

        send(10'd229, 10'd126);
        chk("width_last_id", obs_id, 3'd2);
        chk("width_last_ox", obs_x_rom, 10'd9);
        tick(); tick();
        chk("width_last_rgb", rgb, 12'h456);

        send(10'd230, 10'd120);
        chk("width_past_id", obs_id, 3'd0);
        tick(); tick();
        chk("width_past_rgb", rgb, 12'h0F0);

        send(10'd200, 10'd120);
        chk("width_first_id", obs_id, 3'd2);
        chk("width_first_ox", obs_x_rom, 10'd0);
        chk("width_first_oy", obs_y_rom, 10'd0);
        tick(); tick();
        chk("width_first_rgb", rgb, 12'h456);
        tick();
        chk("hold_valid", rgb_valid, 1'b0);
        chk("hold_rgb", rgb, 12'h456);

        send(10'd50, 10'd5);
        tick(); tick();
        chk("bg_rgb", rgb, 12'h123);

        // Mid-frame input changes must not reach the addresses.
        camera_y = 5'd2; char_abs_x = 14'd999;
        send(10'd300, 10'd20);
        chk("midframe_cx", char_x_rom, 10'd0);
        chk("midframe_cy", char_y_rom, 10'd0);
        tick(); tick();

        // Frame N: char over obstacle 4.
        camera_y = 5'd1; char_abs_x = 14'd300;
        set_obs(4, 300, 500, 5);
        pulse_frame();
        chk("frame_n_flags", collision_flags, 7'h00);
        send(10'd310, 10'd25);
        chk("coll_id", obs_id, 3'd4);
        tick(); tick();
        chk("char_over_obs", rgb, 12'hABC);
        chk("flags_midframe", collision_flags, 7'h00);
        pulse_frame();
        chk("coll_flags", collision_flags, 7'b0010000);
        chk("coll_any", collision_any, 1'b1);

        char_rgb = 12'hF0F;
        send(10'd310, 10'd25);
        tick(); tick();
        chk("char_transp_obs", rgb, 12'h456);
        char_rgb = 12'hABC;
        pulse_frame();
        chk("coll_cleared", collision_flags, 7'h00);
        chk("coll_any_cleared", collision_any, 1'b0);

        // Build a collision again, then reset asynchronously mid-stream.
        send(10'd310, 10'd25);
        tick(); tick();
        pulse_frame();
        chk("coll_again", collision_flags, 7'b0010000);
        x = 10'd310; y = 10'd25; pix_valid = 1'b1;
        tick(); tick();
        #2 sys_rst = 1'b1;
        #1;
        chk("async_rgb", rgb, 12'h000);
        chk("async_valid", rgb_valid, 1'b0);
        chk("async_flags", collision_flags, 7'h00);
        tick();
        sys_rst = 1'b0;
        tick();
        pix_valid = 1'b0;
        chk("post_rst_cx", char_x_rom, 10'd310);
        chk("post_rst_cy", char_y_rom, 10'd25);
        tick();
        chk("post_rst_early", rgb_valid, 1'b0);
        tick();
        chk("post_rst_valid", rgb_valid, 1'b1);
        chk("post_rst_rgb", rgb, 12'h0F0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
